// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: size encodings, FSM state
// encodings and the raw (unshifted) mask/data helpers.
package store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BEAT0  = 3'd1,
        ST_BEAT1  = 3'd2,
        ST_FINISH = 3'd3,
        ST_REJECT = 3'd4
    } state_t;

    // Byte enables of an unshifted store; 2'b11 behaves as a word.
    function automatic logic [3:0] raw_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: raw_mask = 4'b0001;
            SIZE_HALF: raw_mask = 4'b0011;
            default:   raw_mask = 4'b1111;
        endcase
    endfunction

    // Register data trimmed to the store size, still in lane 0.
    function automatic logic [31:0] raw_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: raw_data = {24'b0, data[7:0]};
            SIZE_HALF: raw_data = {16'b0, data[15:0]};
            default:   raw_data = data;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_align.sv
// Combinational lane aligner: places the sized store data and its byte
// enables into an 8-lane (two-word) window starting at the byte offset,
// and flags stores that break natural alignment.
module store_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [63:0] data_shifted,
    output logic [7:0]  mask_shifted,
    output logic        misaligned
);

    logic [31:0] raw_d;
    logic [3:0]  raw_m;

    assign raw_d = raw_data(size, data);
    assign raw_m = raw_mask(size);

    // Lane gi of the window takes source byte (gi - offset); the 3-bit
    // difference has bit 2 set exactly when that source byte does not exist.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [2:0] src;
        logic       hit;
        assign src = 3'(gi) - {1'b0, offset};
        assign hit = ~src[2];
        assign data_shifted[8*gi +: 8] = hit ? raw_d[{src[1:0], 3'b000} +: 8] : 8'h00;
        assign mask_shifted[gi]        = hit & raw_m[src[1:0]];
    end

    // Natural alignment: halves on even offsets, words on offset 0.
    always_comb begin
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = offset[0];
            default:   misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time, aligns it into byte lanes and
// drives the data-memory write port, holding each beat until acknowledged.
// Build option: define STORE_SPLIT_EN to allow misaligned stores, which are
// split into two beats; otherwise misaligned stores are rejected with a
// one-cycle MISALIGNED pulse.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  STORE_REQ,
    input  logic [1:0]            STORE_SIZE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           DATA_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  MISALIGNED,
    output logic                  WR_REQ,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [31:0]           WR_DATA,
    output logic [3:0]            WR_STROBE,
    input  logic                  WR_ACK
);

    state_t state_reg;
    state_t state_next;

    logic [63:0] align_data;
    logic [7:0]  align_mask;
    logic        align_misaligned;
    logic        accept;

    logic [ADDR_WIDTH-1:0] base_reg;

`ifdef STORE_SPLIT_EN
    // Both words of the window are kept; the upper one feeds beat 1.
    logic [63:0] data_reg;
    logic [7:0]  mask_reg;
    logic        unused_align;
    assign unused_align = align_misaligned;
`else
    // Aligned stores never reach the upper word, so only beat 0 is kept.
    logic [31:0] data_reg;
    logic [3:0]  mask_reg;
    logic        unused_align;
    assign unused_align = ^{align_data[63:32], align_mask[7:4]};
`endif

    assign accept = (state_reg == ST_IDLE) && STORE_REQ;

    store_align u_align (
        .size         (STORE_SIZE),
        .offset       (ADDRESS[1:0]),
        .data         (DATA_IN),
        .data_shifted (align_data),
        .mask_shifted (align_mask),
        .misaligned   (align_misaligned)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the aligned request at acceptance so the bus fields stay stable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            base_reg <= '0;
            data_reg <= '0;
            mask_reg <= '0;
        end else if (accept) begin
            base_reg <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
`ifdef STORE_SPLIT_EN
            data_reg <= align_data;
            mask_reg <= align_mask;
`else
            data_reg <= align_data[31:0];
            mask_reg <= align_mask[3:0];
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (STORE_REQ) begin
`ifdef STORE_SPLIT_EN
                    state_next = ST_BEAT0;
`else
                    state_next = align_misaligned ? ST_REJECT : ST_BEAT0;
`endif
                end
            end
            ST_BEAT0: begin
                if (WR_ACK) begin
`ifdef STORE_SPLIT_EN
                    state_next = (|mask_reg[7:4]) ? ST_BEAT1 : ST_FINISH;
`else
                    state_next = ST_FINISH;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            ST_BEAT1: begin
                if (WR_ACK) begin
                    state_next = ST_FINISH;
                end
            end
`else
            ST_REJECT: begin
                state_next = ST_IDLE;
            end
`endif
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: everything is a function of the registered state only.
    always_comb begin
        BUSY       = (state_reg != ST_IDLE);
        DONE       = 1'b0;
        MISALIGNED = 1'b0;
        WR_REQ     = 1'b0;
        WR_ADDR    = '0;
        WR_DATA    = '0;
        WR_STROBE  = '0;
        case (state_reg)
            ST_BEAT0: begin
                WR_REQ    = 1'b1;
                WR_ADDR   = base_reg;
                WR_DATA   = data_reg[31:0];
                WR_STROBE = mask_reg[3:0];
            end
`ifdef STORE_SPLIT_EN
            ST_BEAT1: begin
                WR_REQ    = 1'b1;
                WR_ADDR   = base_reg + ADDR_WIDTH'(4);
                WR_DATA   = data_reg[63:32];
                WR_STROBE = mask_reg[7:4];
            end
`else
            ST_REJECT: begin
                MISALIGNED = 1'b1;
            end
`endif
            ST_FINISH: begin
                DONE = 1'b1;
            end
            default: begin
                DONE = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed scenarios followed by random stores, all
// checked cycle by cycle against a byte-level model of the store.
module tb_store_unit;
    import store_unit_pkg::*;

    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          STORE_REQ;
    logic [1:0]    STORE_SIZE;
    logic [AW-1:0] ADDRESS;
    logic [31:0]   DATA_IN;
    logic          BUSY;
    logic          DONE;
    logic          MISALIGNED;
    logic          WR_REQ;
    logic [AW-1:0] WR_ADDR;
    logic [31:0]   WR_DATA;
    logic [3:0]    WR_STROBE;
    logic          WR_ACK;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    store_unit #(.ADDR_WIDTH(AW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .STORE_REQ  (STORE_REQ),
        .STORE_SIZE (STORE_SIZE),
        .ADDRESS    (ADDRESS),
        .DATA_IN    (DATA_IN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .MISALIGNED (MISALIGNED),
        .WR_REQ     (WR_REQ),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .WR_STROBE  (WR_STROBE),
        .WR_ACK     (WR_ACK)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: walk the store byte by byte, group bytes by the word
    // they land in, and produce the list of write beats (or a rejection).
    int          m_nbeats;
    logic        m_reject;
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_strb [2];

    task automatic model(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int          nbytes;
        int          lane;
        logic [31:0] a;
        logic [31:0] w;
        nbytes   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        m_nbeats = 0;
        m_reject = 1'b0;
`ifndef STORE_SPLIT_EN
        if ((addr % nbytes) != 0) begin
            m_reject = 1'b1;
            return;
        end
`endif
        for (int k = 0; k < nbytes; k++) begin
            a    = addr + k;
            w    = a & ~32'd3;
            lane = int'(a % 4);
            if (m_nbeats == 0 || m_addr[m_nbeats-1] != w) begin
                m_addr[m_nbeats] = w;
                m_data[m_nbeats] = '0;
                m_strb[m_nbeats] = '0;
                m_nbeats++;
            end
            m_data[m_nbeats-1][8*lane +: 8] = data[8*k +: 8];
            m_strb[m_nbeats-1][lane]        = 1'b1;
        end
    endtask

    // One complete store from idle back to idle, with 'waits' stall cycles per beat.
    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input int waits);
        model(size, addr, data);
        check($sformatf("%s busy_before", tag), 32'(BUSY), 32'd0);
        STORE_REQ  = 1'b1;
        STORE_SIZE = size;
        ADDRESS    = addr;
        DATA_IN    = data;
        step();
        STORE_REQ  = 1'b0;
        STORE_SIZE = 2'($urandom);
        ADDRESS    = $urandom;
        DATA_IN    = $urandom;
        if (m_reject) begin
            check($sformatf("%s misaligned", tag), 32'(MISALIGNED), 32'd1);
            check($sformatf("%s rej_wr_req", tag), 32'(WR_REQ), 32'd0);
            check($sformatf("%s rej_busy", tag), 32'(BUSY), 32'd1);
            check($sformatf("%s rej_done", tag), 32'(DONE), 32'd0);
            step();
            check($sformatf("%s rej_mis_clear", tag), 32'(MISALIGNED), 32'd0);
            check($sformatf("%s rej_idle", tag), 32'(BUSY), 32'd0);
            check($sformatf("%s rej_done2", tag), 32'(DONE), 32'd0);
            check($sformatf("%s rej_wr_req2", tag), 32'(WR_REQ), 32'd0);
        end else begin
            for (int b = 0; b < m_nbeats; b++) begin
                for (int c = 0; c <= waits; c++) begin
                    check($sformatf("%s b%0d wr_req", tag, b), 32'(WR_REQ), 32'd1);
                    check($sformatf("%s b%0d wr_addr", tag, b), WR_ADDR, m_addr[b]);
                    check($sformatf("%s b%0d wr_data", tag, b), WR_DATA, m_data[b]);
                    check($sformatf("%s b%0d wr_strobe", tag, b), 32'(WR_STROBE), 32'(m_strb[b]));
                    check($sformatf("%s b%0d busy", tag, b), 32'(BUSY), 32'd1);
                    check($sformatf("%s b%0d done", tag, b), 32'(DONE), 32'd0);
                    check($sformatf("%s b%0d mis", tag, b), 32'(MISALIGNED), 32'd0);
                    WR_ACK = (c == waits);
                    step();
                    WR_ACK = 1'b0;
                end
            end
            check($sformatf("%s done", tag), 32'(DONE), 32'd1);
            check($sformatf("%s fin_wr_req", tag), 32'(WR_REQ), 32'd0);
            check($sformatf("%s fin_busy", tag), 32'(BUSY), 32'd1);
            step();
            check($sformatf("%s done_clear", tag), 32'(DONE), 32'd0);
            check($sformatf("%s idle", tag), 32'(BUSY), 32'd0);
            check($sformatf("%s idle_wr_req", tag), 32'(WR_REQ), 32'd0);
        end
        $display("store %s size=%0d addr=%h data=%h waits=%0d beats=%0d reject=%0b",
                 tag, size, addr, data, waits, m_nbeats, m_reject);
    endtask

    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ra;

    initial begin
        RESET      = 1'b1;
        STORE_REQ  = 1'b0;
        STORE_SIZE = 2'b00;
        ADDRESS    = '0;
        DATA_IN    = '0;
        WR_ACK     = 1'b0;
        step();
        step();
        check("rst busy", 32'(BUSY), 32'd0);
        check("rst done", 32'(DONE), 32'd0);
        check("rst mis", 32'(MISALIGNED), 32'd0);
        check("rst wr_req", 32'(WR_REQ), 32'd0);
        check("rst wr_addr", WR_ADDR, 32'd0);
        check("rst wr_data", WR_DATA, 32'd0);
        check("rst wr_strobe", 32'(WR_STROBE), 32'd0);
        RESET = 1'b0;
        step();

        // Directed scenarios.
        do_store("byte_1003", SIZE_BYTE, 32'h0000_1003, 32'hAABB_CCDD, 0);
        do_store("half_2002_w3", SIZE_HALF, 32'h0000_2002, 32'h1234_5678, 3);
        do_store("word_3001", SIZE_WORD, 32'h0000_3001, 32'h1122_3344, 0);
        do_store("half_3003", SIZE_HALF, 32'h0000_3003, 32'hFFFF_BEEF, 1);
        do_store("word_wrap", SIZE_WORD, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1);
        do_store("size11_word", 2'b11, 32'h0000_6004, 32'h0BAD_CAFE, 0);

        // Reset during an unacknowledged beat aborts the store.
        STORE_REQ  = 1'b1;
        STORE_SIZE = SIZE_WORD;
        ADDRESS    = 32'h0000_4000;
        DATA_IN    = 32'h5555_AAAA;
        step();
        STORE_REQ = 1'b0;
        check("midrst wr_req_before", 32'(WR_REQ), 32'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrst wr_req", 32'(WR_REQ), 32'd0);
        check("midrst busy", 32'(BUSY), 32'd0);
        check("midrst done", 32'(DONE), 32'd0);
        check("midrst strobe", 32'(WR_STROBE), 32'd0);
        step();
        check("midrst done_later", 32'(DONE), 32'd0);
        $display("store midrst aborted addr=00004000");
        do_store("after_rst", SIZE_WORD, 32'h0000_4000, 32'hCAFE_F00D, 0);

        // Back-to-back: request held high, second one accepted only in idle.
        va = 32'h0102_0304;
        vb = 32'hF0E0_D0C0;
        STORE_REQ  = 1'b1;
        STORE_SIZE = SIZE_WORD;
        ADDRESS    = 32'h0000_5000;
        DATA_IN    = va;
        step();
        ADDRESS = 32'h0000_5008;
        DATA_IN = vb;
        check("b2b a wr_req", 32'(WR_REQ), 32'd1);
        check("b2b a wr_addr", WR_ADDR, 32'h0000_5000);
        check("b2b a wr_data", WR_DATA, va);
        check("b2b a strobe", 32'(WR_STROBE), 32'hF);
        WR_ACK = 1'b1;
        step();
        WR_ACK = 1'b0;
        check("b2b a done", 32'(DONE), 32'd1);
        check("b2b a fin_wr_req", 32'(WR_REQ), 32'd0);
        step();
        check("b2b gap busy", 32'(BUSY), 32'd0);
        check("b2b gap wr_req", 32'(WR_REQ), 32'd0);
        check("b2b gap done", 32'(DONE), 32'd0);
        step();
        STORE_REQ = 1'b0;
        check("b2b b wr_req", 32'(WR_REQ), 32'd1);
        check("b2b b wr_addr", WR_ADDR, 32'h0000_5008);
        check("b2b b wr_data", WR_DATA, vb);
        WR_ACK = 1'b1;
        step();
        WR_ACK = 1'b0;
        check("b2b b done", 32'(DONE), 32'd1);
        step();
        check("b2b b idle", 32'(BUSY), 32'd0);
        $display("store b2b two words 00005000 then 00005008");

        // Random stores, some near the top of the address space.
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            if ($urandom_range(3) == 0) begin
                ra = 32'hFFFF_FFFC | 32'($urandom_range(3));
            end
            do_store($sformatf("rnd%0d", i), 2'($urandom), ra, $urandom, int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
